// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Walks the byte-addressed program counter through the four bytes of each
// 32-bit instruction, assembles them big-endian and hands the word to decode
// on a valid/ready handshake. At the handshake it fires exactly one PC strobe:
// a jump or branch when execute requests a redirect, otherwise a step to the
// next instruction.
//
// Parameters
//   MEM_LAT           cycles from a stable memory address to valid mem_rdata
//                     (1..3; the latency counter is 2 bits wide)
//
// Ports
//   clk               clock, rising edge
//   rst_n             asynchronous, active-low reset
//   start             leave IDLE and begin fetching at the current PC
//   halt              return to IDLE after the handshake it coincides with
//   mem_rdata  [7:0]  byte read from the address held by the PC
//   pc_lsbs    [1:0]  PC bits [1:0], compared against the byte lane at capture
//   instr_ready       decode accepts instr
//   redir_valid       redirect the next fetch (only looked at on a handshake)
//   redir_is_branch   1 = relative branch, 0 = absolute jump
//   redir_target [5:0] jump instruction index or branch offset
//   update_lsbs       PC: advance to the next byte
//   update_msbs       PC: advance to the next instruction
//   jump              PC: load jump_destination
//   brancher          PC: add branch_offset
//   jump_destination  redir_target while jump=1, else 0
//   branch_offset     redir_target while brancher=1, else 0
//   instr     [31:0]  assembled instruction
//   instr_valid       instr holds a complete instruction
//   fetch_err         sticky lane-mismatch flag, cleared by reset or start
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic [7:0]  mem_rdata,
  input  logic [1:0]  pc_lsbs,
  input  logic        instr_ready,
  input  logic        redir_valid,
  input  logic        redir_is_branch,
  input  logic [5:0]  redir_target,
  output logic        update_lsbs,
  output logic        update_msbs,
  output logic        jump,
  output logic        brancher,
  output logic [5:0]  jump_destination,
  output logic [5:0]  branch_offset,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [1:0] LAT_MAX = 2'(MEM_LAT);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_byte_cnt;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_instr;
  logic        r_fetch_err;
  logic        w_capture;
  logic        w_handshake;

  // The byte on mem_rdata is valid once the address has been stable for
  // MEM_LAT cycles, i.e. on the last cycle of each byte slot.
  assign w_capture   = (r_state == S_FETCH) && (r_lat_cnt == LAT_MAX);
  assign w_handshake = (r_state == S_ISSUE) && instr_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_FETCH;
      S_FETCH: if (w_capture && (r_byte_cnt == 2'd3)) w_next_state = S_ISSUE;
      S_ISSUE: if (w_handshake) w_next_state = halt ? S_IDLE : S_FETCH;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte/latency counters, instruction assembly, lane check
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt  <= 2'd0;
      r_lat_cnt   <= 2'd0;
      r_instr     <= 32'd0;
      r_fetch_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_byte_cnt  <= 2'd0;
            r_lat_cnt   <= 2'd0;
            r_fetch_err <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_capture) begin
            r_lat_cnt <= 2'd0;
            case (r_byte_cnt)
              2'd0: r_instr[31:24] <= mem_rdata;
              2'd1: r_instr[23:16] <= mem_rdata;
              2'd2: r_instr[15:8]  <= mem_rdata;
              2'd3: r_instr[7:0]   <= mem_rdata;
            endcase
            // The last byte leaves byte_cnt at 3 to match the PC lsbs; it is
            // rewound when the instruction is handed off.
            if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
            // Flag only; the sequence carries on regardless.
            if (pc_lsbs != r_byte_cnt) r_fetch_err <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end
        S_ISSUE: begin
          if (w_handshake) begin
            r_byte_cnt <= 2'd0;
            r_lat_cnt  <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: PC strobes are combinational so the PC moves on the same
  // edge that consumes the byte or the instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    update_lsbs      = 1'b0;
    update_msbs      = 1'b0;
    jump             = 1'b0;
    brancher         = 1'b0;
    jump_destination = 6'd0;
    branch_offset    = 6'd0;
    unique case (r_state)
      // No strobe on the fourth byte: the PC lsbs stay at 3 until the
      // handshake moves the PC to the next instruction.
      S_FETCH: update_lsbs = w_capture && (r_byte_cnt != 2'd3);
      S_ISSUE: begin
        if (w_handshake) begin
          if (!redir_valid) begin
            update_msbs = 1'b1;
          end else if (redir_is_branch) begin
            brancher      = 1'b1;
            branch_offset = redir_target;
          end else begin
            jump             = 1'b1;
            jump_destination = redir_target;
          end
        end
      end
      default: ;
    endcase
  end

  assign instr_valid = (r_state == S_ISSUE);
  assign instr       = r_instr;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Surrounds fetch_sequencer with a program counter and a byte memory with
// MEM_LAT cycles of read latency. A transaction-level model (idle / fetching
// for a given age / issuing) predicts every output each cycle and a single
// compare process on the falling edge checks the DUT against it. A directed
// sequence walks the documented scenarios and pins the model with literal
// expectations (first instruction word, PC after each redirect, sticky error).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int M         = 1;
  localparam int BYTE_CYC  = M + 1;
  localparam int FETCH_CYC = 4 * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic [7:0]  mem_rdata;
  logic [1:0]  pc_lsbs;
  logic        instr_ready;
  logic        redir_valid;
  logic        redir_is_branch;
  logic [5:0]  redir_target;
  logic        update_lsbs;
  logic        update_msbs;
  logic        jump;
  logic        brancher;
  logic [5:0]  jump_destination;
  logic [5:0]  branch_offset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_LAT(M)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .halt             (halt),
    .mem_rdata        (mem_rdata),
    .pc_lsbs          (pc_lsbs),
    .instr_ready      (instr_ready),
    .redir_valid      (redir_valid),
    .redir_is_branch  (redir_is_branch),
    .redir_target     (redir_target),
    .update_lsbs      (update_lsbs),
    .update_msbs      (update_msbs),
    .jump             (jump),
    .brancher         (brancher),
    .jump_destination (jump_destination),
    .branch_offset    (branch_offset),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .fetch_err        (fetch_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment: program counter and latency memory
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:255];
  logic [7:0] pc;
  logic [7:0] addr_q [0:M-1];
  logic       force_en;
  logic [1:0] force_val;

  assign pc_lsbs   = force_en ? force_val : pc[1:0];
  assign mem_rdata = mem[addr_q[M-1]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc <= 8'h00;
    else if (update_lsbs) pc <= {pc[7:2], pc[1:0] + 2'd1};
    else if (update_msbs) pc <= {pc[7:2] + 6'd1, 2'b00};
    else if (jump)        pc <= {jump_destination, 2'b00};
    else if (brancher)    pc <= {pc[7:2] + branch_offset, 2'b00};
  end

  always @(posedge clk) begin
    addr_q[0] <= pc;
    for (int i = 1; i < M; i++) addr_q[i] <= addr_q[i-1];
  end

  function automatic logic [31:0] word_at(input logic [5:0] idx);
    return {mem[{idx, 2'd0}], mem[{idx, 2'd1}], mem[{idx, 2'd2}], mem[{idx, 2'd3}]};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model + per-cycle compare
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_FETCH, M_ISSUE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_age  = 0;
  bit     m_err  = 1'b0;

  always @(negedge clk) begin : cmp
    logic [3:0] e_strb;   // {update_lsbs, update_msbs, jump, brancher}
    logic [5:0] e_dest;
    logic [5:0] e_off;
    logic       e_valid;
    mmode_t     n_mode;
    int         n_age;
    bit         n_err;
    int         b;
    if (!rst_n) begin
      check("reset_outputs",
            32'({update_lsbs, update_msbs, jump, brancher, instr_valid, fetch_err,
                 jump_destination, branch_offset}), 32'd0);
      check("reset_instr", instr, 32'd0);
      m_mode = M_IDLE;
      m_age  = 0;
      m_err  = 1'b0;
    end else begin
      e_strb  = 4'd0;
      e_dest  = 6'd0;
      e_off   = 6'd0;
      e_valid = 1'b0;
      n_mode  = m_mode;
      n_age   = m_age;
      n_err   = m_err;
      b       = 0;
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            n_mode = M_FETCH;
            n_age  = 0;
            n_err  = 1'b0;
          end
        end
        M_FETCH: begin
          if ((m_age % BYTE_CYC) == M) begin
            b = m_age / BYTE_CYC;
            if (b < 3) e_strb[3] = 1'b1;
            if (int'(pc_lsbs) != b) n_err = 1'b1;
          end
          if (m_age == FETCH_CYC - 1) n_mode = M_ISSUE;
          else                        n_age  = m_age + 1;
        end
        M_ISSUE: begin
          e_valid = 1'b1;
          check("instr_word", instr, word_at(pc[7:2]));
          if (instr_ready) begin
            if (!redir_valid) begin
              e_strb[2] = 1'b1;
            end else if (redir_is_branch) begin
              e_strb[0] = 1'b1;
              e_off     = redir_target;
            end else begin
              e_strb[1] = 1'b1;
              e_dest    = redir_target;
            end
            n_mode = halt ? M_IDLE : M_FETCH;
            n_age  = 0;
          end
        end
        default: ;
      endcase
      check("strobes", 32'({update_lsbs, update_msbs, jump, brancher}), 32'(e_strb));
      check("instr_valid", 32'(instr_valid), 32'(e_valid));
      check("fetch_err", 32'(fetch_err), 32'(m_err));
      check("redir_fields", 32'({jump_destination, branch_offset}), 32'({e_dest, e_off}));
      m_mode = n_mode;
      m_age  = n_age;
      m_err  = n_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 100) begin
      tick();
      n++;
    end
    check("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic handshake(input logic rv, input logic br, input logic [5:0] tgt, input logic h);
    int n;
    wait_valid(n);
    instr_ready     = 1'b1;
    redir_valid     = rv;
    redir_is_branch = br;
    redir_target    = tgt;
    halt            = h;
    tick();
    instr_ready     = 1'b0;
    redir_valid     = 1'b0;
    redir_is_branch = 1'b0;
    redir_target    = 6'd0;
    halt            = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h8C;
    mem[1] = 8'h22;
    mem[2] = 8'h00;
    mem[3] = 8'h04;
    rst_n           = 1'b0;
    start           = 1'b0;
    halt            = 1'b0;
    instr_ready     = 1'b0;
    redir_valid     = 1'b0;
    redir_is_branch = 1'b0;
    redir_target    = 6'd0;
    force_en        = 1'b0;
    force_val       = 2'd0;
    #2;
    check("rst_instr", instr, 32'd0);
    check("rst_flags", 32'({update_lsbs, update_msbs, jump, brancher, instr_valid, fetch_err}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // First instruction from 0x00, plain handshake.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    check("first_latency", 32'(n), 32'(FETCH_CYC));
    check("first_instr", instr, 32'h8C220004);
    instr_ready = 1'b1;
    #1;
    check("first_hs_strobe", 32'({update_lsbs, update_msbs, jump, brancher}), 32'b0100);
    tick();
    instr_ready = 1'b0;
    check("pc_after_first", 32'(pc), 32'h04);

    // Stall in ISSUE with halt/start/redirect noise that must be ignored.
    wait_valid(n);
    held         = instr;
    halt         = 1'b1;
    start        = 1'b1;
    redir_valid  = 1'b1;
    redir_target = 6'h2A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr, held);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    halt         = 1'b0;
    start        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 6'd0;
    handshake(1'b0, 1'b0, 6'd0, 1'b0);
    check("pc_after_stall", 32'(pc), 32'h08);

    // Absolute jump to index 0x10; the next fetch addresses 0x40.
    handshake(1'b1, 1'b0, 6'h10, 1'b0);
    check("pc_after_jump", 32'(pc), 32'h40);
    for (int i = 0; i < M; i++) tick();
    check("fetch_addr_after_jump", 32'(addr_q[M-1]), 32'h40);

    // Jump to 0x04, branch +2 -> 0x0C, jump to 0x3F, plain step wraps to 0x00.
    handshake(1'b1, 1'b0, 6'h01, 1'b0);
    check("pc_after_jump1", 32'(pc), 32'h04);
    handshake(1'b1, 1'b1, 6'h02, 1'b0);
    check("pc_after_branch", 32'(pc), 32'h0C);
    handshake(1'b1, 1'b0, 6'h3F, 1'b0);
    check("pc_after_jump3f", 32'(pc), 32'hFC);
    handshake(1'b0, 1'b0, 6'd0, 1'b0);
    check("pc_wrap", 32'(pc), 32'h00);

    // Asynchronous reset while fetching byte 2.
    n = 0;
    while (pc != 8'h02 && n < 50) begin
      tick();
      n++;
    end
    check("reach_byte2", 32'(pc), 32'h02);
    rst_n = 1'b0;
    #1;
    check("async_rst_flags",
          32'({update_lsbs, update_msbs, jump, brancher, instr_valid, fetch_err}), 32'd0);
    check("async_rst_instr", instr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("pc_after_rst", 32'(pc), 32'h00);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    check("refetch_instr", instr, 32'h8C220004);
    handshake(1'b0, 1'b0, 6'd0, 1'b0);

    // Lane mismatch on byte 1 of the instruction at 0x04.
    n = 0;
    while (pc[1:0] != 2'd1 && n < 50) begin
      tick();
      n++;
    end
    force_en  = 1'b1;
    force_val = 2'd2;
    n = 0;
    while (pc[1:0] != 2'd2 && n < 50) begin
      tick();
      n++;
    end
    force_en = 1'b0;
    check("fetch_err_set", 32'(fetch_err), 32'd1);
    handshake(1'b0, 1'b0, 6'd0, 1'b0);
    check("err_no_stall_pc", 32'(pc), 32'h08);
    wait_valid(n);
    check("err_sticky", 32'(fetch_err), 32'd1);

    // Halt at the handshake: PC still advances, then nothing moves.
    handshake(1'b0, 1'b0, 6'd0, 1'b1);
    check("pc_after_halt", 32'(pc), 32'h0C);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_quiet", 32'({update_lsbs, update_msbs, jump, brancher, instr_valid}), 32'd0);
    end
    check("err_held_idle", 32'(fetch_err), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cleared_by_start", 32'(fetch_err), 32'd0);
    handshake(1'b0, 1'b0, 6'd0, 1'b1);
    check("pc_after_halt2", 32'(pc), 32'h10);
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
